// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: ROM entry layout, note codes,
// the octave-0 half-period table (25 MHz clock) and the playback FSM states.
package tone_pkg;

  localparam int unsigned MELODY_MAX  = 256;
  localparam int unsigned ENTRY_W     = 9;
  localparam int unsigned MELODY_BITS = MELODY_MAX * ENTRY_W;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam int CODE_MSB = 8;
  localparam int CODE_LSB = 5;
  localparam int OCT_MSB  = 4;
  localparam int OCT_LSB  = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_DECODE = 2'd2,
    S_PLAY   = 2'd3
  } state_e;

  // Octave-0 half periods (C4..B4) in 25 MHz cycles; 0 marks a silent code.
  function automatic logic [15:0] base_half_period(input logic [3:0] code);
    logic [15:0] hp;
    case (code)
      4'd1:    hp = 16'd47778;
      4'd2:    hp = 16'd45097;
      4'd3:    hp = 16'd42566;
      4'd4:    hp = 16'd40177;
      4'd5:    hp = 16'd37922;
      4'd6:    hp = 16'd35793;
      4'd7:    hp = 16'd33784;
      4'd8:    hp = 16'd31888;
      4'd9:    hp = 16'd30098;
      4'd10:   hp = 16'd28409;
      4'd11:   hp = 16'd26815;
      4'd12:   hp = 16'd25310;
      default: hp = 16'd0;
    endcase
    return hp;
  endfunction

  function automatic logic [ENTRY_W-1:0] entry(input logic [3:0] code,
                                               input logic [1:0] oct,
                                               input logic [2:0] dur_m1);
    return {code, oct, dur_m1};
  endfunction

  localparam logic [MELODY_BITS-1:0] DEFAULT_MELODY = MELODY_BITS'({
    entry(NOTE_END, 2'd0, 3'd0),
    entry(4'd1,  2'd1, 3'd3),
    entry(4'd5,  2'd1, 3'd1),
    entry(4'd8,  2'd1, 3'd1),
    entry(NOTE_REST, 2'd0, 3'd0),
    entry(4'd8,  2'd1, 3'd1),
    entry(4'd5,  2'd1, 3'd1),
    entry(4'd1,  2'd1, 3'd1)
  });

endpackage

// File: rtl/melody_rom.sv
// Melody storage: synchronous-read ROM, one 9-bit entry per 8-bit address,
// contents supplied as a packed parameter (entry i at bits [9*i +: 9]).
module melody_rom
  import tone_pkg::*;
#(
  parameter logic [MELODY_BITS-1:0] MELODY = DEFAULT_MELODY
) (
  input  logic               clk,
  input  logic [7:0]         addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] data_q;

  always_ff @(posedge clk) begin
    data_q <= MELODY[int'(addr) * ENTRY_W +: ENTRY_W];
  end

  assign data = data_q;

endmodule

// File: rtl/tone_sequencer.sv
// Plays a ROM melody as a square wave on a differential piezo drive; each entry
// gives note, octave and duration, with a short silent gap ending every note.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25000000,
  parameter int unsigned UNIT_CYCLES = 3125000,
  parameter int unsigned MELODY_LEN  = 32,
  parameter bit          LOOP        = 1'b0,
  parameter logic [MELODY_BITS-1:0] MELODY = DEFAULT_MELODY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [7:0] note_addr,
  output logic       spkp,
  output logic       spkm,
  output logic [1:0] state_dbg
);

  localparam logic [31:0] GAP_CYCLES = 32'(UNIT_CYCLES / 8);
  localparam logic [8:0]  LEN_9      = 9'(MELODY_LEN);
  localparam logic [7:0]  LAST_ADDR  = 8'(MELODY_LEN - 1);

  // The pitch table is only in tune at 25 MHz; CLK_HZ records the clock in use.
  if (CLK_HZ != 25000000) begin : g_retuned_clock
  end

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   dur_q, dur_d;
  logic [15:0]   tone_q, tone_d;
  logic [15:0]   half_q, half_d;
  logic          spk_q, spk_d;

  logic [ENTRY_W-1:0] rom_data;
  logic [3:0]         rom_code;
  logic [1:0]         rom_oct;
  logic [2:0]         rom_dur;
  logic [31:0]        dur_load;
  logic               is_end;
  logic               gap;
  logic               spk_on;

  melody_rom #(.MELODY(MELODY)) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (rom_data)
  );

  assign rom_code = rom_data[CODE_MSB:CODE_LSB];
  assign rom_oct  = rom_data[OCT_MSB:OCT_LSB];
  assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];
  assign dur_load = (32'(rom_dur) + 32'd1) * UNIT_CYCLES - 32'd1;
  assign is_end   = (rom_code == NOTE_END) || ({1'b0, addr_q} == LEN_9);

  // Handshake: start is a level sampled on each rising edge and is accepted
  // only in IDLE; there is no ready, busy reports that playback is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_ADDR;
      S_ADDR:   state_d = S_DECODE;
      S_DECODE: begin
        if (is_end) state_d = LOOP ? S_ADDR : S_IDLE;
        else        state_d = S_PLAY;
      end
      S_PLAY:   if (dur_q == '0) state_d = S_ADDR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    dur_d  = dur_q;
    tone_d = tone_q;
    half_d = half_q;
    spk_d  = spk_q;
    unique case (state_q)
      S_DECODE: begin
        if (is_end) begin
          addr_d = '0;
          spk_d  = 1'b0;
        end else begin
          dur_d  = dur_load;
          half_d = base_half_period(rom_code) >> rom_oct;
          tone_d = '0;
          spk_d  = 1'b0;
        end
      end
      S_PLAY: begin
        // A zero half period marks a rest: the speaker bit never toggles.
        if (tone_q == half_q - 16'd1) begin
          tone_d = '0;
          spk_d  = ~spk_q & (half_q != '0);
        end else begin
          tone_d = tone_q + 16'd1;
        end
        if (dur_q == '0) begin
          addr_d = (LOOP && addr_q == LAST_ADDR) ? 8'd0 : addr_q + 8'd1;
          spk_d  = 1'b0;
        end else begin
          dur_d = dur_q - 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      dur_q  <= '0;
      tone_q <= '0;
      half_q <= '0;
      spk_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dur_q  <= dur_d;
      tone_q <= tone_d;
      half_q <= half_d;
      spk_q  <= spk_d;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    gap       = (state_q == S_PLAY) && (dur_q < GAP_CYCLES);
    spk_on    = spk_q & ~gap;
    spkp      = busy & spk_on;
    spkm      = busy & ~spk_on;
    note_addr = addr_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: three instances (single-shot, looping, long-unit)
// checked every cycle against a timeline model built from the melody tables.
module tb_tone_sequencer;

  localparam logic [8:0] A0 = {4'd10, 2'd2, 3'd0};
  localparam logic [8:0] A1 = {4'd0,  2'd0, 3'd1};
  localparam logic [8:0] A2 = {4'd7,  2'd1, 3'd2};
  localparam logic [8:0] A3 = {4'd15, 2'd0, 3'd0};
  localparam logic [8:0] B0 = {4'd0,  2'd0, 3'd0};
  localparam logic [8:0] B1 = {4'd3,  2'd1, 3'd1};
  localparam logic [8:0] B2 = {4'd13, 2'd0, 3'd0};
  localparam logic [8:0] B3 = {4'd12, 2'd3, 3'd0};
  localparam logic [8:0] C0 = {4'd1,  2'd0, 3'd7};
  localparam logic [8:0] C1 = {4'd8,  2'd3, 3'd0};
  localparam logic [8:0] C2 = {4'd15, 2'd0, 3'd0};

  localparam logic [2303:0] MEL_A = 2304'({A3, A2, A1, A0});
  localparam logic [2303:0] MEL_B = 2304'({B3, B2, B1, B0});
  localparam logic [2303:0] MEL_C = 2304'({C2, C1, C0});

  int mel [3][4] = '{'{int'(A0), int'(A1), int'(A2), int'(A3)},
                     '{int'(B0), int'(B1), int'(B2), int'(B3)},
                     '{int'(C0), int'(C1), int'(C2), 0}};
  int len_of  [3] = '{4, 4, 3};
  int loop_of [3] = '{0, 1, 0};
  int unit_of [3] = '{16, 16, 8000};
  int base [12] = '{47778, 45097, 42566, 40177, 37922, 35793,
                    33784, 31888, 30098, 28409, 26815, 25310};

  logic       clk;
  logic [2:0] rst_v, start_v, busy_v, spkp_v, spkm_v;
  logic [7:0] addr_v [3];
  logic [1:0] st_v [3];
  int         t_v [3];
  int         n_pass, n_fail, n_total;

  tone_sequencer #(.UNIT_CYCLES(16), .MELODY_LEN(4), .LOOP(1'b0), .MELODY(MEL_A)) u_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]),
    .note_addr(addr_v[0]), .spkp(spkp_v[0]), .spkm(spkm_v[0]), .state_dbg(st_v[0]));

  tone_sequencer #(.UNIT_CYCLES(16), .MELODY_LEN(4), .LOOP(1'b1), .MELODY(MEL_B)) u_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]),
    .note_addr(addr_v[1]), .spkp(spkp_v[1]), .spkm(spkm_v[1]), .state_dbg(st_v[1]));

  tone_sequencer #(.UNIT_CYCLES(8000), .MELODY_LEN(3), .LOOP(1'b0), .MELODY(MEL_C)) u_c (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]),
    .note_addr(addr_v[2]), .spkp(spkp_v[2]), .spkm(spkm_v[2]), .state_dbg(st_v[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t = 0 is the cycle in which start is high in IDLE; negative means idle.
  // Each entry occupies one ADDR cycle, one DECODE cycle, then (dur+1)*unit
  // PLAY cycles; tone level is (k / half) mod 2, zeroed in the last unit/8.
  function automatic void model(input int d, input int t,
                                output logic e_busy, output logic [7:0] e_addr,
                                output logic e_p, output logic e_m,
                                output logic [1:0] e_st);
    int pos, addr, ent, code, oct, dlen, k, half, lvl;
    e_busy = 1'b0; e_addr = 8'd0; e_p = 1'b0; e_m = 1'b0; e_st = 2'd0;
    if (t < 1) return;
    pos = 1;
    addr = 0;
    for (int guard = 0; guard < 100000; guard++) begin
      if (t == pos || t == pos + 1) begin
        e_busy = 1'b1; e_addr = 8'(addr); e_m = 1'b1;
        e_st = (t == pos) ? 2'd1 : 2'd2;
        return;
      end
      ent  = (addr < len_of[d]) ? mel[d][addr] : 0;
      code = ent / 32;
      oct  = (ent / 8) % 4;
      if (addr == len_of[d] || code == 15) begin
        if (loop_of[d] == 0) return;
        addr = 0;
        pos  = pos + 2;
        continue;
      end
      dlen = (ent % 8 + 1) * unit_of[d];
      if (t < pos + 2 + dlen) begin
        k   = t - pos - 2;
        lvl = 0;
        if (code >= 1 && code <= 12) begin
          half = base[code - 1] / (1 << oct);
          lvl  = (k / half) % 2;
        end
        if (dlen - 1 - k < unit_of[d] / 8) lvl = 0;
        e_busy = 1'b1; e_addr = 8'(addr); e_st = 2'd3;
        e_p = (lvl != 0); e_m = (lvl == 0);
        return;
      end
      pos  = pos + 2 + dlen;
      addr = (addr + 1) % 256;
      if (loop_of[d] != 0 && addr == len_of[d]) addr = 0;
    end
  endfunction

  function automatic bit busy_now(input int d);
    logic eb, ep, em;
    logic [7:0] ea;
    logic [1:0] es;
    model(d, t_v[d], eb, ea, ep, em, es);
    return eb;
  endfunction

  // scoreboard
  task automatic chk(input int d, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL dut%0d %s t=%0d: observed %0h expected %0h", d, what, t_v[d], obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic eb, ep, em;
    logic [7:0] ea;
    logic [1:0] es;
    model(d, t_v[d], eb, ea, ep, em, es);
    chk(d, "busy",      32'(busy_v[d]), 32'(eb));
    chk(d, "note_addr", 32'(addr_v[d]), 32'(ea));
    chk(d, "spkp",      32'(spkp_v[d]), 32'(ep));
    chk(d, "spkm",      32'(spkm_v[d]), 32'(em));
    chk(d, "state",     32'(st_v[d]),   32'(es));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) if (t_v[d] >= 0) t_v[d]++;
    for (int d = 0; d < 3; d++) check_dut(d);
  endtask

  task automatic kick(input int d);
    start_v[d] = 1'b1;
    if (!busy_now(d)) t_v[d] = 0;
  endtask

  task automatic reset_mid(input int d);
    #2;
    rst_v[d] = 1'b1;
    #1;
    t_v[d] = -1;
    check_dut(d);
    @(negedge clk);
    rst_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy_now(d)) break;
      step();
    end
    chk(d, "idle_within_budget", 32'(busy_v[d]), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    t_v = '{-1, -1, -1};
    rst_v = 3'b111;
    start_v = 3'b000;
    #1;
    for (int d = 0; d < 3; d++) check_dut(d);
    step();
    @(negedge clk);
    rst_v = 3'b000;
    repeat (3) step();

    // long-unit melody runs in the background for the rest of the test
    kick(2);
    step();
    start_v[2] = 1'b0;
    repeat ($urandom_range(0, 5)) step();

    kick(0);
    kick(1);
    step();
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;

    // extra start pulses while busy must be ignored
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++)
        if (busy_now(d) && $urandom_range(0, 3) == 0) start_v[d] = 1'b1;
      step();
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
    end
    wait_idle(0, 500);

    // reset in the middle of entry 0, then replay from entry 0
    repeat ($urandom_range(0, 6)) step();
    kick(0);
    step();
    start_v[0] = 1'b0;
    repeat ($urandom_range(2, 17)) step();
    reset_mid(0);
    repeat ($urandom_range(1, 4)) step();
    kick(0);
    step();
    start_v[0] = 1'b0;
    wait_idle(0, 500);

    // the looping instance only stops on reset
    repeat ($urandom_range(0, 40)) step();
    chk(1, "loop_still_busy", 32'(busy_v[1]), 32'd1);
    reset_mid(1);
    step();

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 10)) step();
      kick(0);
      step();
      start_v[0] = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (busy_now(0) && $urandom_range(0, 4) == 0) start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
      end
      wait_idle(0, 500);
    end

    wait_idle(2, 80000);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, the clk frequency in Hz, used only to document the pitch table.
REQ-002 SHALL have parameter UNIT_CYCLES, default 3125000, the clk cycles per duration unit (125 ms).
REQ-003 SHALL have parameter MELODY_LEN, default 32, the number of ROM entries (max 256).
REQ-004 SHALL have parameter LOOP, default 0; when 1, playback restarts at entry 0 instead of stopping.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, from the 25 MHz PLL output.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: sampled-high pulse that starts playback.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until playback ends.
REQ-009 SHALL have port note_addr, output, 8 bits: the current ROM address.
REQ-010 SHALL have port spkp, output, 1 bit: positive speaker drive.
REQ-011 SHALL have port spkm, output, 1 bit: negative speaker drive.

Function
REQ-012 SHALL decode each 9-bit ROM entry as: [8:5] note code (0 = rest, 1..12 = C..B, 15 = END, 13..14 treated as rest); [4:3] octave 0..3; [2:0] duration-1.
REQ-013 SHALL use a 16-bit half-period table for octave 0 (C4..B4 at 25 MHz): 47778, 45097, 42566, 40177, 37922, 35793, 33784, 31888, 30098, 28409, 26815, 25310.
REQ-014 SHALL shift the table value right by the octave to form the half-period; no rounding.
REQ-015 SHALL implement FSM states IDLE, ADDR, DECODE, PLAY.
REQ-016 SHALL move IDLE->ADDR when start is high; start in any other state SHALL be ignored.
REQ-017 SHALL drive note_addr to the ROM in ADDR, with registered ROM data valid in DECODE (one-cycle latency).
REQ-018 SHALL handle an END code in DECODE, or note_addr = MELODY_LEN, by returning to IDLE when LOOP=0, or setting note_addr to 0 and going to ADDR when LOOP=1.
REQ-019 SHALL, for any other code in DECODE: load the duration counter with (dur+1)*UNIT_CYCLES-1, load the half-period, clear the tone counter, set the speaker bit to 0, and go to PLAY.
REQ-020 SHALL, in PLAY, increment the tone counter each cycle; when it equals half-period-1, toggle the speaker bit and clear the counter.
REQ-021 SHALL hold the speaker bit at 0 for a rest.
REQ-022 SHALL force the speaker bit to 0 during the last UNIT_CYCLES/8 cycles of every note (articulation gap).
REQ-023 SHALL decrement the duration counter each PLAY cycle; at 0, increment note_addr (8-bit wrap) and go to ADDR.
REQ-024 SHALL give start-to-PLAY latency of exactly 3 cycles (start sampled at edge n; ADDR at n+1, DECODE at n+2, PLAY at n+3).
REQ-025 SHALL hold busy = 0 only in IDLE.
REQ-026 SHALL drive spkp = speaker bit and spkm = ~speaker bit while busy, and spkp = spkm = 0 in IDLE (no DC across the piezo).
REQ-027 SHALL compute the duration product with at least 32-bit width; no overflow is permitted for UNIT_CYCLES <= 2^28.

Reset
REQ-028 SHALL, on rst asserted asynchronously: enter state IDLE; set note_addr = 0, busy = 0, spkp = 0, spkm = 0; clear the tone and duration counters and the speaker bit.
REQ-029 SHALL abort playback immediately when rst is asserted mid-note; after release, the next start SHALL begin at entry 0.

Structure
REQ-030 SHALL place in package tone_pkg: the note-code constants (REST, END), the entry field positions, the half-period table, and the FSM state enum.
REQ-031 SHALL implement the melody contents in one sub-module, melody_rom (8-bit address in, registered 9-bit data out, synchronous read).

Verification (UNIT_CYCLES=16, MELODY_LEN=4)
REQ-032 SHALL verify: ROM {A oct2 dur0, END}; start pulse -> busy at +1, PLAY at +3, speaker toggles every 7102 cycles (28409>>2), note lasts 16 cycles, silent for the last 2, then busy drops.
REQ-033 SHALL verify: rest entry dur=1 -> spkp = spkm... spkp = 0 and spkm = 1 for 32 cycles, note_addr increments afterwards.
REQ-034 SHALL verify: start pulsed again while busy -> no restart, note_addr sequence unchanged.
REQ-035 SHALL verify: LOOP=1, no END, 4 entries -> note_addr goes 0,1,2,3,0; busy stays high.
REQ-036 SHALL verify: rst asserted mid-PLAY -> on the same edge spkp = spkm = 0, busy = 0, note_addr = 0; a restart replays entry 0.
REQ-037 SHALL verify: C oct0 -> first toggle occurs 47778 cycles after PLAY entry, confirming the 16-bit counter carries no truncation.
